// File: rtl/nonce_search_controller.sv
// Nonce search sequencer: clears the incrementer, launches one hash per nonce,
// compares each digest against the job target, and reports found/exhausted/fault.
module nonce_search_controller #(
    parameter int HASH_W  = 256,
    parameter int TIMEOUT = 1024
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              job_valid,
    output logic              job_ready,
    input  logic [HASH_W-1:0] job_target,
    input  logic              abort,
    input  logic [31:0]       nonce,
    output logic              nonce_update,
    output logic              nonce_clear,
    output logic              hash_start,
    input  logic              hash_done,
    input  logic [HASH_W-1:0] hash_digest,
    output logic              found_valid,
    output logic [31:0]       found_nonce,
    output logic              exhausted,
    output logic              fault,
    output logic              busy
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    typedef enum logic [3:0] {
        IDLE,
        CLEAR,
        START,
        WAIT,
        CHECK,
        STEP,
        FOUND,
        EXHAUSTED,
        FAULT
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [HASH_W-1:0] target_q;
    logic [31:0]       nonce_q;
    logic [CNT_W-1:0]  tmo_q;
    logic              hit_q;
    logic              terminal;

    assign terminal = (state == FOUND) || (state == EXHAUSTED) || (state == FAULT);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:      if (job_valid && job_ready) state_nxt = CLEAR;
            CLEAR:     state_nxt = START;
            START:     state_nxt = WAIT;
            WAIT: begin
                // Fault when this decrement would bring the counter to zero,
                // landing FAULT exactly TIMEOUT cycles after hash_start.
                if (hash_done)                     state_nxt = CHECK;
                else if (tmo_q <= CNT_W'(1))       state_nxt = FAULT;
            end
            CHECK: begin
                if (hit_q)                         state_nxt = FOUND;
                else if (nonce_q == 32'hFFFF_FFFF) state_nxt = EXHAUSTED;
                else                               state_nxt = STEP;
            end
            STEP:      state_nxt = START;
            FOUND, EXHAUSTED, FAULT:
                       if (job_valid) state_nxt = CLEAR;
            default:   state_nxt = IDLE;
        endcase
        if (abort) state_nxt = IDLE;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            job_ready    <= 1'b0;
            busy         <= 1'b0;
            nonce_clear  <= 1'b0;
            nonce_update <= 1'b0;
            hash_start   <= 1'b0;
            found_valid  <= 1'b0;
            exhausted    <= 1'b0;
            fault        <= 1'b0;
            found_nonce  <= '0;
            target_q     <= '0;
            nonce_q      <= '0;
            tmo_q        <= '0;
            hit_q        <= 1'b0;
        end else begin
            state        <= state_nxt;
            job_ready    <= (state_nxt == IDLE);
            busy         <= (state_nxt != IDLE);
            nonce_clear  <= (state_nxt == CLEAR);
            nonce_update <= (state_nxt == STEP);
            hash_start   <= (state_nxt == START);
            found_valid  <= (state_nxt == FOUND);
            exhausted    <= (state_nxt == EXHAUSTED);
            fault        <= (state_nxt == FAULT);

            if (state_nxt == CLEAR && (state == IDLE || terminal))
                target_q <= job_target;

            if (state == START) begin
                nonce_q <= nonce;
                tmo_q   <= CNT_W'(TIMEOUT - 1);
            end

            if (state == WAIT) begin
                tmo_q <= tmo_q - CNT_W'(1);
                if (hash_done)
                    hit_q <= (hash_digest < target_q);
            end

            if (state == CHECK && state_nxt == FOUND)
                found_nonce <= nonce_q;
        end
    end

endmodule

// File: tb/tb_nonce_search_controller.sv
// Directed bench for nonce_search_controller with behavioural incrementer and hash core.
module tb_nonce_search_controller;

    localparam int HASH_W  = 256;
    localparam int TIMEOUT = 16;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              job_valid = 1'b0;
    logic              job_ready;
    logic [HASH_W-1:0] job_target = '0;
    logic              abort = 1'b0;
    logic [31:0]       nonce = '0;
    logic              nonce_update;
    logic              nonce_clear;
    logic              hash_start;
    logic              hash_done = 1'b0;
    logic [HASH_W-1:0] hash_digest = '0;
    logic              found_valid;
    logic [31:0]       found_nonce;
    logic              exhausted;
    logic              fault;
    logic              busy;

    nonce_search_controller #(.HASH_W(HASH_W), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset(reset), .job_valid(job_valid), .job_ready(job_ready),
        .job_target(job_target), .abort(abort), .nonce(nonce),
        .nonce_update(nonce_update), .nonce_clear(nonce_clear), .hash_start(hash_start),
        .hash_done(hash_done), .hash_digest(hash_digest), .found_valid(found_valid),
        .found_nonce(found_nonce), .exhausted(exhausted), .fault(fault), .busy(busy)
    );

    always #5 clk = ~clk;

    // Behavioural incrementer and hash core
    logic [31:0]       clear_value = '0;
    logic              core_en = 1'b1;
    logic              hit_all = 1'b0;
    logic [31:0]       hit_nonce = '0;
    logic [HASH_W-1:0] hit_digest = '0;
    logic [HASH_W-1:0] miss_digest = '1;
    int                lat = 4;
    int                core_rem = 0;
    logic [31:0]       core_nonce = '0;

    always @(posedge clk) begin
        if (nonce_clear)       nonce <= clear_value;
        else if (nonce_update) nonce <= nonce + 32'd1;
    end

    always @(posedge clk) begin
        hash_done <= 1'b0;
        if (core_rem != 0) begin
            core_rem <= core_rem - 1;
            if (core_rem == 1) begin
                hash_done   <= 1'b1;
                hash_digest <= (hit_all || core_nonce == hit_nonce) ? hit_digest : miss_digest;
            end
        end
        if (hash_start && core_en) begin
            core_rem   <= lat - 1;
            core_nonce <= nonce;
        end
    end

    int cyc = 0, n_clear = 0, n_update = 0, n_start = 0;
    int last_start = -1, period = 0, start_cyc = 0;
    logic [31:0] start_nonce = '0;

    always @(negedge clk) begin
        cyc = cyc + 1;
        if (nonce_clear)  n_clear = n_clear + 1;
        if (nonce_update) n_update = n_update + 1;
        if (hash_start) begin
            n_start = n_start + 1;
            if (last_start >= 0) period = cyc - last_start;
            last_start  = cyc;
            start_cyc   = cyc;
            start_nonce = nonce;
        end
    end

    int checks = 0, errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks = checks + 1;
        if (got !== exp) begin
            errors = errors + 1;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic send_job(input logic [HASH_W-1:0] tgt);
        job_target = tgt;
        job_valid  = 1'b1;
        tick();
        job_valid  = 1'b0;
    endtask

    int b_clear, b_update, b_start, t0;

    initial begin
        #1;
        check("rst_outputs", {job_ready, busy, nonce_clear, nonce_update, hash_start,
                              found_valid, exhausted, fault}, 8'h00);
        check("rst_found_nonce", found_nonce, 0);
        tick(); tick();
        reset = 1'b1;
        tick();
        check("idle_job_ready", {job_ready, busy}, 2'b10);

        // Target all-ones, every digest zero: immediate hit at nonce 0
        hit_all = 1'b1; hit_digest = '0; clear_value = '0;
        b_clear = n_clear; b_update = n_update; b_start = n_start;
        send_job('1);
        check("t1_clear_pulse", {nonce_clear, job_ready, busy}, 3'b101);
        tick();
        check("t1_start_pulse", {hash_start, nonce_clear}, 2'b10);
        check("t1_start_nonce", nonce, 0);
        for (int i = 0; i < 50 && !found_valid; i++) tick();
        check("t1_found", found_valid, 1);
        check("t1_found_nonce", found_nonce, 0);
        check("t1_counts", {8'(n_clear - b_clear), 8'(n_start - b_start), 8'(n_update - b_update)}, 24'h010100);
        abort = 1'b1; tick(); abort = 1'b0;
        check("t1_abort_idle", {job_ready, busy, found_valid}, 3'b100);

        // Hit only at nonce 5, equal-to-target digests must miss
        hit_all = 1'b0; hit_nonce = 32'd5;
        hit_digest = 256'h0FFF; miss_digest = 256'h1000;
        b_clear = n_clear; b_update = n_update; b_start = n_start;
        send_job(256'h1000);
        for (int i = 0; i < 200 && !found_valid; i++) tick();
        check("t2_found", {found_valid, exhausted, fault}, 3'b100);
        check("t2_found_nonce", found_nonce, 5);
        check("t2_starts", n_start - b_start, 6);
        check("t2_updates", n_update - b_update, 5);
        check("t2_period", period, 7);

        // Restart from FOUND near the top of the nonce space, never hit
        clear_value = 32'hFFFF_FFFE; miss_digest = '1;
        b_clear = n_clear; b_update = n_update; b_start = n_start;
        send_job(256'h1000);
        check("t3_restart_clear", {nonce_clear, found_valid}, 2'b10);
        for (int i = 0; i < 100 && !exhausted; i++) tick();
        check("t3_exhausted", {exhausted, found_valid}, 2'b10);
        check("t3_starts", n_start - b_start, 2);
        check("t3_updates", n_update - b_update, 1);
        check("t3_last_nonce", start_nonce, 32'hFFFF_FFFF);
        abort = 1'b1; tick(); abort = 1'b0;
        check("t3_abort_idle", {job_ready, exhausted}, 2'b10);

        // Core never answers: fault exactly TIMEOUT cycles after hash_start
        core_en = 1'b0; clear_value = '0;
        b_start = n_start;
        send_job('1);
        for (int i = 0; i < 100 && !fault; i++) tick();
        check("t4_fault", fault, 1);
        check("t4_fault_delay", cyc - start_cyc, TIMEOUT);
        check("t4_one_start", n_start - b_start, 1);
        abort = 1'b1; tick(); abort = 1'b0;
        check("t4_abort_idle", {job_ready, busy, fault}, 3'b100);

        // Abort in the same cycle as a hitting hash_done
        core_en = 1'b1; hit_all = 1'b1; hit_digest = '0;
        b_update = n_update; b_start = n_start;
        send_job('1);
        for (int i = 0; i < 50 && !hash_done; i++) tick();
        check("t5_done_seen", hash_done, 1);
        abort = 1'b1; tick(); abort = 1'b0;
        check("t5_abort_idle", {job_ready, busy, found_valid}, 3'b100);
        for (int i = 0; i < 10; i++) tick();
        check("t5_quiet", {8'(n_start - b_start), 8'(n_update - b_update), 7'd0, found_valid}, 24'h010000);

        // Asynchronous reset while in WAIT
        b_start = n_start;
        send_job('1);
        for (int i = 0; i < 20 && (n_start == b_start); i++) tick();
        tick();
        check("t6_in_wait", {busy, hash_start}, 2'b10);
        #2 reset = 1'b0;
        #1;
        check("t6_async_clear", {job_ready, busy, nonce_clear, nonce_update, hash_start,
                                 found_valid, exhausted, fault}, 8'h00);
        tick();
        reset = 1'b1;
        tick();
        check("t6_ready_after", job_ready, 1);
        for (int i = 0; i < 6; i++) tick();
        b_clear = n_clear;
        send_job('1);
        check("t6_new_clear", nonce_clear, 1);
        for (int i = 0; i < 50 && !found_valid; i++) tick();
        check("t6_found", {found_valid, found_nonce}, {1'b1, 32'd0});

        t0 = cyc;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
